// File: rtl/mcu_subsys_mem_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them to MCU SRAM.
// Define MCU_LOADER_VERIFY_EN to read back and compare every written word.
module mcu_subsys_mem_loader #(
    parameter int LEN_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len_bytes,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
`ifdef MCU_LOADER_VERIFY_EN
    localparam logic [2:0] S_VERIFY  = 3'd4;
`endif

    logic [2:0]        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       buf_q, buf_d;
    logic [3:0]        strb_q, strb_d;
    logic [1:0]        idx_q, idx_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              word_done;
    logic              in_bus;

`ifdef MCU_LOADER_VERIFY_EN
    logic [31:0] lane_mask;
    assign lane_mask = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};
    assign in_bus    = (state_q == S_WRITE) || (state_q == S_VERIFY);
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign in_bus       = (state_q == S_WRITE);
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        strb_d    = strb_q;
        idx_d     = idx_q;
        remain_d  = remain_q;
        wait_d    = wait_q;
        err_d     = err_q;
        word_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr & ~32'h3;
                    remain_d = len_bytes;
                    err_d    = 1'b0;
                    buf_d    = '0;
                    strb_d   = '0;
                    idx_d    = '0;
                    state_d  = (len_bytes == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (s_valid) begin
                    buf_d[{idx_q, 3'b000} +: 8] = s_data;
                    strb_d[idx_q]               = 1'b1;
                    remain_d                    = remain_q - 1'b1;
                    idx_d                       = idx_q + 2'd1;
                    if (idx_q == 2'd3 || remain_q == LEN_W'(1)) begin
                        state_d = S_WRITE;
                        wait_d  = '0;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
`ifdef MCU_LOADER_VERIFY_EN
                    state_d = S_VERIFY;
                    wait_d  = '0;
`else
                    word_done = 1'b1;
`endif
                end
            end
`ifdef MCU_LOADER_VERIFY_EN
            S_VERIFY: begin
                if (mem_ready) begin
                    if (((mem_rdata ^ buf_q) & lane_mask) != '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        word_done = 1'b1;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Shared bus timeout for the write and the optional read-back.
        if (in_bus && !mem_ready) begin
            if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        if (word_done) begin
            addr_d  = addr_q + 32'd4;
            buf_d   = '0;
            strb_d  = '0;
            idx_d   = '0;
            state_d = (remain_q == '0) ? S_DONE : S_COLLECT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            buf_q    <= '0;
            strb_q   <= '0;
            idx_q    <= '0;
            remain_q <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            strb_q   <= strb_d;
            idx_q    <= idx_d;
            remain_q <= remain_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign s_ready   = (state_q == S_COLLECT);
    assign mem_valid = in_bus;
    assign mem_addr  = addr_q;
    assign mem_wdata = buf_q;
    assign mem_wstrb = (state_q == S_WRITE) ? strb_q : 4'b0000;

endmodule

// File: tb/tb_mcu_subsys_mem_loader.sv
// Randomized bench for mcu_subsys_mem_loader: expected bus writes are derived from the
// byte list (little-endian packing, +4 addresses) and checked against observed handshakes.
module tb_mcu_subsys_mem_loader;

    localparam int LEN_W    = 16;
    localparam int WAIT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      base_addr = '0;
    logic [LEN_W-1:0] len_bytes = '0;
    logic             busy, done, err, s_ready, mem_valid;
    logic             s_valid = 1'b0;
    logic [7:0]       s_data = '0;
    logic             mem_ready = 1'b0;
    logic [31:0]      mem_addr, mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata = '0;

    mcu_subsys_mem_loader #(.LEN_W(LEN_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .len_bytes(len_bytes), .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state: bytes still to be offered and the writes they must produce.
    logic [7:0]  src_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_strb[$];

    int  rmode = 0;
    int  stall_left = 0;
    bit  dense = 1'b1;
    bit  fixed = 1'b0;
    bit  corrupt = 1'b0;
    int  wr_seen = 0, rd_seen = 0, done_cnt = 0, valid_cnt = 0, bytes_taken = 0;
    logic [31:0] last_addr = '0, last_data = '0;
    logic [3:0]  last_strb = '0;
    bit          stalled = 1'b0;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_strb;
    logic [7:0]  tmp_byte;

    // Stream source and memory responder, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 2 && mem_valid && stall_left > 0) begin
                mem_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else if (rmode == 1) begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end else begin
                mem_ready = 1'b1;
            end
            s_valid = (src_q.size() > 0) && (dense || $urandom_range(0, 2) != 0);
            s_data  = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
`ifdef MCU_LOADER_VERIFY_EN
            mem_rdata = last_data ^ 32'(corrupt && rd_seen == 1);
`else
            mem_rdata = $urandom;
`endif
        end
    end

    // Bus/stream monitor, sampled mid-cycle where all signals are settled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (s_valid && s_ready) begin
                bytes_taken++;
                if (src_q.size() > 0) tmp_byte = src_q.pop_front();
            end
            if (mem_valid) begin
                valid_cnt++;
                check("s_ready_during_bus", 32'(s_ready), 32'd0);
`ifndef MCU_LOADER_VERIFY_EN
                check("wstrb_nonzero", 32'(mem_wstrb != 4'b0), 32'd1);
`endif
                if (stalled) begin
                    check("hold_addr", mem_addr, st_addr);
                    check("hold_data", mem_wdata, st_data);
                    check("hold_strb", 32'(mem_wstrb), 32'(st_strb));
                end
                if (mem_ready) begin
                    stalled = 1'b0;
                    if (mem_wstrb != 4'b0) begin
                        wr_seen++;
                        last_addr = mem_addr;
                        last_data = mem_wdata;
                        last_strb = mem_wstrb;
                        if (exp_addr.size() == 0) begin
                            check("extra_write", 32'd1, 32'd0);
                        end else begin
                            check("wr_addr", mem_addr, exp_addr.pop_front());
                            check("wr_data", mem_wdata, exp_data.pop_front());
                            check("wr_strb", 32'(mem_wstrb), 32'(exp_strb.pop_front()));
                        end
                    end else begin
                        rd_seen++;
                    end
                end else begin
                    stalled = 1'b1;
                    st_addr = mem_addr;
                    st_data = mem_wdata;
                    st_strb = mem_wstrb;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Fill the stream and expected-write list for one transfer; returns the word count.
    function automatic int build_model(input logic [31:0] base, input int len);
        logic [7:0]  bq[$];
        logic [31:0] d;
        logic [3:0]  s;
        int          nw;
        for (int i = 0; i < len; i++) begin
            bq.push_back(fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom));
            src_q.push_back(bq[i]);
        end
        nw = (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            s = '0;
            for (int j = 0; j < 4; j++) begin
                if (w * 4 + j < len) begin
                    d[j*8 +: 8] = bq[w*4 + j];
                    s[j]        = 1'b1;
                end
            end
            exp_addr.push_back((base & ~32'h3) + 32'(4 * w));
            exp_data.push_back(d);
            exp_strb.push_back(s);
        end
        return nw;
    endfunction

    task automatic flush_model();
        src_q.delete();
        exp_addr.delete();
        exp_data.delete();
        exp_strb.delete();
    endtask

    task automatic run_xfer(input logic [31:0] base, input int len, input int mode,
                            input int hold, input bit dns, input bit junk,
                            input int exp_writes, input bit exp_err, output int cyc);
        int nw;
        bit got;
        nw         = build_model(base, len);
        rmode      = mode;
        stall_left = hold;
        dense      = dns;
        wr_seen    = 0;
        rd_seen    = 0;
        done_cnt   = 0;
        base_addr  = base;
        len_bytes  = LEN_W'(len);
        start      = 1'b1;
        cyc        = 0;
        got        = 1'b0;
        while (cyc < 20000 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("err_cleared", 32'(err), 32'd0);
            end
            if (done) begin
                got = 1'b1;
            end else if (junk && $urandom_range(0, 5) == 0) begin
                start     = 1'b1;
                base_addr = $urandom;
                len_bytes = LEN_W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!got) check("done_timeout", 32'd0, 32'd1);
        check("err_at_done", 32'(err), 32'(exp_err));
        check("no_bus_at_done", 32'(mem_valid), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done_cnt), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
        check("write_count", 32'(wr_seen), 32'((exp_writes < 0) ? nw : exp_writes));
        if (!exp_err) check("bytes_consumed", 32'(src_q.size()), 32'd0);
        flush_model();
        rmode = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int budget;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two full words from a fixed byte pattern with an always-ready responder.
        fixed = 1'b1;
        run_xfer(32'h0000_0100, 8, 0, 0, 1'b1, 1'b0, -1, 1'b0, cyc);
`ifndef MCU_LOADER_VERIFY_EN
        check("latency_8_bytes", 32'(cyc), 32'd11);
`endif
        check("last_addr_8", last_addr, 32'h0000_0104);
        check("last_data_8", last_data, 32'h8877_6655);
        check("last_strb_8", 32'(last_strb), 32'hF);

        // Unaligned base and a partial final word.
        run_xfer(32'h0000_0203, 6, 0, 0, 1'b1, 1'b0, -1, 1'b0, cyc);
        check("last_addr_6", last_addr, 32'h0000_0204);
        check("last_data_6", last_data, 32'h0000_6655);
        check("last_strb_6", 32'(last_strb), 32'h3);
        fixed = 1'b0;

        // Zero-length transfer; a start during the DONE cycle must be ignored.
        valid_cnt = 0;
        done_cnt  = 0;
        base_addr = 32'h40;
        len_bytes = '0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd1);
        len_bytes = LEN_W'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("len0_done_low", 32'(done), 32'd0);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("len0_no_bus", 32'(valid_cnt), 32'd0);
        check("len0_done_count", 32'(done_cnt), 32'd1);

        // Stalls: short, one below the limit, and exactly at the limit.
        run_xfer(32'h0000_1000, 8, 2, 10, 1'b1, 1'b0, -1, 1'b0, cyc);
        run_xfer(32'h0000_2000, 4, 2, WAIT_MAX - 1, 1'b1, 1'b0, -1, 1'b0, cyc);
        run_xfer(32'h0000_3000, 8, 2, WAIT_MAX, 1'b1, 1'b0, 0, 1'b1, cyc);
        check("err_sticky_idle", 32'(err), 32'd1);

        // Address wraps past the top of the 32-bit space.
        run_xfer(32'hFFFF_FFFE, 7, 0, 0, 1'b1, 1'b0, -1, 1'b0, cyc);
        check("wrap_last_addr", last_addr, 32'h0000_0000);

        // Reset partway through a 12-byte transfer, then a clean 4-byte transfer.
        void'(build_model(32'h0000_4000, 12));
        dense       = 1'b1;
        bytes_taken = 0;
        base_addr   = 32'h0000_4000;
        len_bytes   = LEN_W'(12);
        start       = 1'b1;
        budget      = 0;
        while (bytes_taken < 5 && budget < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            budget++;
        end
        check("reset_point_reached", 32'(bytes_taken), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        flush_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_xfer(32'h0000_5004, 4, 0, 0, 1'b0, 1'b0, -1, 1'b0, cyc);

`ifdef MCU_LOADER_VERIFY_EN
        // Read-back mismatch on the second word aborts before a third write.
        corrupt = 1'b1;
        run_xfer(32'h0000_6000, 12, 0, 0, 1'b1, 1'b0, 2, 1'b1, cyc);
        check("verify_reads", 32'(rd_seen), 32'd2);
        corrupt = 1'b0;
`endif

        // Randomized transfers with random stream gaps, bus stalls and stray starts.
        for (int t = 0; t < 25; t++) begin
            run_xfer($urandom, $urandom_range(1, 40), 1, 0, 1'($urandom_range(0, 1)),
                     1'b1, -1, 1'b0, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
